// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
//
// Purpose:
//   A single-port 256 x 16 word memory with a registered, 1-cycle-latency read
//   path. A READ may be issued every cycle. An illegal command raises a sticky
//   error flag.
//
//   When MEM_MMIO_EN is defined, address bit 8 selects a small MMIO space
//   instead of RAM:
//     9'h100  read/write : LED register (low byte)
//     9'h140  read only  : switches, after a 2-flop synchroniser
//     others             : read as zero, writes ignored
//   When MEM_MMIO_EN is not defined, address bit 8 is ignored, so every
//   address aliases to RAM. The LEDs are tied low and the switches are unused.
//
// Ports:
//   clk         in   1  : clock, rising-edge active
//   reset_n     in   1  : asynchronous, active-low reset
//   mem_cmd     in   2  : 00 NONE, 01 READ, 10 WRITE, 11 illegal
//   mem_addr    in   9  : word address
//   write_data  in  16  : store value, sampled with WRITE
//   read_data   out 16  : registered read result, holds between reads
//   read_valid  out  1  : high in the cycle that read_data is a fresh result
//   sw          in   8  : asynchronous board switches
//   led         out  8  : registered LED drive
//   cmd_err     out  1  : sticky flag, set by an illegal command
// ----------------------------------------------------------------------------
module mem_responder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        read_valid,
  input  logic [7:0]  sw,
  output logic [7:0]  led,
  output logic        cmd_err
);

  localparam logic [1:0] CMD_NONE    = 2'b00;
  localparam logic [1:0] CMD_READ    = 2'b01;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_ILLEGAL = 2'b11;

  // --------------------------------------------------------------------------
  // Command decode
  // --------------------------------------------------------------------------
  logic is_read;
  logic is_write;
  logic is_illegal;

  always_comb begin
    is_read    = 1'b0;
    is_write   = 1'b0;
    is_illegal = 1'b0;
    case (mem_cmd)
      CMD_NONE:    ;
      CMD_READ:    is_read    = 1'b1;
      CMD_WRITE:   is_write   = 1'b1;
      CMD_ILLEGAL: is_illegal = 1'b1;
      default:     ;
    endcase
  end

  // High when the access targets the MMIO space rather than RAM.
  logic mmio_sel;

  // --------------------------------------------------------------------------
  // RAM storage. There is no reset, so the contents survive a reset pulse.
  // A write that coincides with reset is dropped, which treats reset as an
  // abort of the access in flight.
  // --------------------------------------------------------------------------
  logic [15:0] ram_mem [0:255];

  always_ff @(posedge clk) begin
    if (is_write && !mmio_sel && reset_n) begin
      ram_mem[mem_addr[7:0]] <= write_data;
    end
  end

  // --------------------------------------------------------------------------
  // MMIO space (optional)
  // --------------------------------------------------------------------------
  logic [15:0] mmio_rd_word;

`ifdef MEM_MMIO_EN
  localparam logic [8:0] ADDR_LED = 9'h100;
  localparam logic [8:0] ADDR_SW  = 9'h140;
  localparam int         SYNC_STAGES = 2;

  logic [7:0] led_reg;
  logic [7:0] sw_stage_reg [0:SYNC_STAGES-1];
  logic [7:0] sw_sync;

  assign mmio_sel = mem_addr[8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_reg <= 8'h00;
    end else if (is_write && mem_addr == ADDR_LED) begin
      led_reg <= write_data[7:0];
    end
  end

  // Switch synchroniser chain: stage 0 samples the pins, and each later
  // stage re-times the previous one.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sw_sync
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sw_stage_reg[gi] <= 8'h00;
        end else if (gi == 0) begin
          sw_stage_reg[gi] <= sw;
        end else begin
          sw_stage_reg[gi] <= sw_stage_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign sw_sync = sw_stage_reg[SYNC_STAGES-1];
  assign led     = led_reg;

  always_comb begin
    mmio_rd_word = 16'h0000;
    case (mem_addr)
      ADDR_LED: mmio_rd_word = {8'h00, led_reg};
      ADDR_SW:  mmio_rd_word = {8'h00, sw_sync};
      default:  mmio_rd_word = 16'h0000;
    endcase
  end
`else
  // Without MMIO, bit 8 takes no part in decoding and the switches are not
  // sampled at all.
  logic unused_inputs;

  assign mmio_sel      = 1'b0;
  assign mmio_rd_word  = 16'h0000;
  assign led           = 8'h00;
  assign unused_inputs = ^{sw, mem_addr[8]};
`endif

  // --------------------------------------------------------------------------
  // Registered read path and error flag. The RAM is read combinationally
  // into the output register, so there is one cycle of latency. A word
  // written at the previous edge is already in the array when it is read.
  // --------------------------------------------------------------------------
  logic [15:0] read_data_reg;
  logic [15:0] read_data_next;
  logic        read_valid_reg;
  logic        cmd_err_reg;

  always_comb begin
    read_data_next = read_data_reg;
    if (is_read) begin
      read_data_next = mmio_sel ? mmio_rd_word : ram_mem[mem_addr[7:0]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data_reg  <= 16'h0000;
      read_valid_reg <= 1'b0;
      cmd_err_reg    <= 1'b0;
    end else begin
      read_data_reg  <= read_data_next;
      read_valid_reg <= is_read;
      if (is_illegal) begin
        cmd_err_reg <= 1'b1;
      end
    end
  end

  assign read_data  = read_data_reg;
  assign read_valid = read_valid_reg;
  assign cmd_err    = cmd_err_reg;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_READ  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_ILL   = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        read_valid;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic        cmd_err;

  int checks = 0;
  int errors = 0;

  mem_responder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .read_valid (read_valid),
    .sw         (sw),
    .led        (led),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic [7:0]  exp_led;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one command just after an edge, then sample 1 time unit after the
  // edge that consumes it.
  task automatic apply(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wdata);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] wdata,
                     input logic ev, input logic [15:0] ed, input logic [7:0] el);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.wdata = wdata;
    v.exp_valid = ev; v.exp_data = ed; v.exp_led = el;
    vecs.push_back(v);
  endtask

  initial begin
    // Write-then-read, back-to-back reads and hold behaviour.
    add(C_WRITE, 9'h012, 16'hBEEF, 1'b0, 16'h0000, 8'h00);
    add(C_READ,  9'h012, 16'h0000, 1'b1, 16'hBEEF, 8'h00);
    add(C_NONE,  9'h012, 16'h0000, 1'b0, 16'hBEEF, 8'h00);
    add(C_WRITE, 9'h001, 16'h1111, 1'b0, 16'hBEEF, 8'h00);
    add(C_WRITE, 9'h002, 16'h2222, 1'b0, 16'hBEEF, 8'h00);
    add(C_WRITE, 9'h003, 16'h3333, 1'b0, 16'hBEEF, 8'h00);
    add(C_READ,  9'h001, 16'h0000, 1'b1, 16'h1111, 8'h00);
    add(C_READ,  9'h002, 16'h0000, 1'b1, 16'h2222, 8'h00);
    add(C_READ,  9'h003, 16'h0000, 1'b1, 16'h3333, 8'h00);
    add(C_NONE,  9'h000, 16'h0000, 1'b0, 16'h3333, 8'h00);
    add(C_WRITE, 9'h0FF, 16'hABCD, 1'b0, 16'h3333, 8'h00);
    add(C_WRITE, 9'h105, 16'h7777, 1'b0, 16'h3333, 8'h00);
`ifdef MEM_MMIO_EN
    add(C_READ,  9'h0FF, 16'h0000, 1'b1, 16'hABCD, 8'h00);
    add(C_READ,  9'h105, 16'h0000, 1'b1, 16'h0000, 8'h00);
    add(C_READ,  9'h012, 16'h0000, 1'b1, 16'hBEEF, 8'h00);
`else
    add(C_READ,  9'h005, 16'h0000, 1'b1, 16'h7777, 8'h00);
    add(C_READ,  9'h1FF, 16'h0000, 1'b1, 16'hABCD, 8'h00);
    add(C_WRITE, 9'h100, 16'h00A5, 1'b0, 16'hABCD, 8'h00);
    add(C_READ,  9'h000, 16'h0000, 1'b1, 16'h00A5, 8'h00);
`endif

    // Reset state, checked while reset is held and before any edge.
    reset_n = 1'b0; mem_cmd = C_NONE; mem_addr = 9'h000; write_data = 16'h0000; sw = 8'h00;
    #1;
    chk("reset_read_data", read_data, 16'h0000);
    chk("reset_read_valid", {15'h0, read_valid}, 16'h0000);
    chk("reset_led", {8'h0, led}, 16'h0000);
    chk("reset_cmd_err", {15'h0, cmd_err}, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].cmd, vecs[i].addr, vecs[i].wdata);
      $display("vec %0d cmd=%b addr=%h wdata=%h -> valid=%b data=%h led=%h err=%b",
               i, vecs[i].cmd, vecs[i].addr, vecs[i].wdata, read_valid, read_data, led, cmd_err);
      chk($sformatf("vec%0d_valid", i), {15'h0, read_valid}, {15'h0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_data", i), read_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_led", i), {8'h0, led}, {8'h0, vecs[i].exp_led});
      chk($sformatf("vec%0d_cmd_err", i), {15'h0, cmd_err}, 16'h0000);
    end

`ifdef MEM_MMIO_EN
    // LED register, switch synchroniser, and ignored write to the switch port.
    apply(C_WRITE, 9'h100, 16'h00A5);
    $display("mmio write 0x100 -> led=%h", led);
    chk("mmio_led_write", {8'h0, led}, 16'h00A5);
    apply(C_READ, 9'h100, 16'h0000);
    $display("mmio read 0x100 -> valid=%b data=%h", read_valid, read_data);
    chk("mmio_led_read", read_data, 16'h00A5);
    chk("mmio_led_read_valid", {15'h0, read_valid}, 16'h0001);
    sw = 8'h3C;
    apply(C_NONE, 9'h000, 16'h0000);
    apply(C_NONE, 9'h000, 16'h0000);
    apply(C_READ, 9'h140, 16'h0000);
    $display("mmio read 0x140 -> valid=%b data=%h", read_valid, read_data);
    chk("mmio_sw_read", read_data, 16'h003C);
    chk("mmio_sw_read_valid", {15'h0, read_valid}, 16'h0001);
    apply(C_WRITE, 9'h140, 16'h1234);
    apply(C_READ, 9'h140, 16'h0000);
    $display("mmio read 0x140 after write -> data=%h led=%h", read_data, led);
    chk("mmio_sw_write_ignored", read_data, 16'h003C);
    chk("mmio_led_unchanged", {8'h0, led}, 16'h00A5);
`endif

    // Illegal command: sticky error, no access, no valid pulse.
    apply(C_ILL, 9'h055, 16'hFFFF);
    $display("illegal cmd -> valid=%b data=%h err=%b", read_valid, read_data, cmd_err);
    chk("ill_cmd_err", {15'h0, cmd_err}, 16'h0001);
    chk("ill_read_valid", {15'h0, read_valid}, 16'h0000);
    apply(C_READ, 9'h012, 16'h0000);
    $display("read after illegal -> valid=%b data=%h err=%b", read_valid, read_data, cmd_err);
    chk("ill_sticky_read", {15'h0, cmd_err}, 16'h0001);
    chk("ill_then_read_data", read_data, 16'hBEEF);
    apply(C_WRITE, 9'h020, 16'h5A5A);
    chk("ill_sticky_write", {15'h0, cmd_err}, 16'h0001);

    // Reset dropped between a READ being presented and its edge: outputs clear
    // at once, and the READ never produces a valid pulse.
    mem_cmd = C_READ; mem_addr = 9'h001; write_data = 16'h0000;
    #2;
    reset_n = 1'b0;
    #1;
    $display("async reset mid-read -> valid=%b data=%h led=%h err=%b", read_valid, read_data, led, cmd_err);
    chk("arst_read_data", read_data, 16'h0000);
    chk("arst_read_valid", {15'h0, read_valid}, 16'h0000);
    chk("arst_cmd_err", {15'h0, cmd_err}, 16'h0000);
    chk("arst_led", {8'h0, led}, 16'h0000);
    @(posedge clk);
    #1;
    chk("arst_no_valid_after_edge", {15'h0, read_valid}, 16'h0000);
    reset_n = 1'b1;

    // First command after reset release is taken at the next edge, and RAM
    // contents survive reset.
    apply(C_READ, 9'h012, 16'h0000);
    $display("first read after reset -> valid=%b data=%h err=%b", read_valid, read_data, cmd_err);
    chk("post_reset_valid", {15'h0, read_valid}, 16'h0001);
    chk("post_reset_data", read_data, 16'hBEEF);
    apply(C_READ, 9'h020, 16'h0000);
    chk("post_reset_ram_kept", read_data, 16'h5A5A);
    apply(C_NONE, 9'h000, 16'h0000);
    chk("post_reset_valid_drop", {15'h0, read_valid}, 16'h0000);
    chk("post_reset_cmd_err", {15'h0, cmd_err}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port mem_cmd, input, 2 bits: 00 = NONE, 01 = READ, 10 = WRITE, 11 = illegal.
REQ-004 The block SHALL have port mem_addr, input, 9 bits: word address.
REQ-005 The block SHALL have port write_data, input, 16 bits: the store value, sampled with WRITE.
REQ-006 The block SHALL have port read_data, output, 16 bits: registered read result.
REQ-007 The block SHALL have port read_valid, output, 1 bit: high for exactly the cycle in which read_data holds a fresh READ result.
REQ-008 The block SHALL have port sw, input, 8 bits: asynchronous board switches.
REQ-009 The block SHALL have port led, output, 8 bits: registered LED drive.
REQ-010 The block SHALL have port cmd_err, output, 1 bit: sticky flag for an illegal command.

Function
REQ-011 The block SHALL contain a 256 x 16 RAM indexed by mem_addr[7:0]; RAM contents are not initialised by reset.
REQ-012 WRITE with mem_addr[8]=0 SHALL store write_data into RAM[mem_addr[7:0]] at the clock edge.
REQ-013 READ at edge N SHALL drive read_data with the addressed word and pulse read_valid during cycle N+1 (1-cycle latency).
REQ-014 READ SHALL be accepted every cycle: back-to-back READs give back-to-back valid data, with read_valid held high continuously.
REQ-015 READ of an address written at the immediately preceding edge SHALL return the newly written value.
REQ-016 On NONE or WRITE, read_valid SHALL be 0 and read_data SHALL hold its last value.
REQ-017 mem_cmd=11 SHALL perform no access, set cmd_err=1 (sticky until reset), and drive read_valid=0.
REQ-018 Bit widths SHALL be exact: there is no address wrap beyond 9 bits, and mem_addr[8] only selects MMIO (REQ-022).

Reset
REQ-019 While reset_n=0, the block SHALL hold read_data=16'h0000, read_valid=0, led=8'h00, cmd_err=0, and the sw synchroniser flops at 0.
REQ-020 Reset asserted mid-access SHALL abort that access: a READ issued in the reset cycle produces no read_valid pulse, and a WRITE coincident with reset_n=0 is not guaranteed to land.
REQ-021 After reset_n deasserts, the block SHALL accept its first command at the next rising edge.

Configuration
REQ-022 With macro MEM_MMIO_EN defined, mem_addr[8]=1 SHALL select MMIO instead of RAM:
- 9'h100 write sets led <= write_data[7:0].
- 9'h100 read returns {8'h00, led}.
- 9'h140 read returns {8'h00, sw_sync}, where sw_sync is sw after a 2-flop synchroniser.
- 9'h140 write is ignored.
- Any other address with bit 8 set reads 16'h0000 and ignores writes.
- Every MMIO read has the same 1-cycle latency as a RAM read.
REQ-023 Without MEM_MMIO_EN, the block SHALL:
- ignore mem_addr[8], so all addresses alias to RAM[mem_addr[7:0]];
- tie led to 8'h00;
- leave sw unused, with no synchroniser flops.

Verification
REQ-024 The bench SHALL cover: WRITE 0x012 <- 16'hBEEF, next cycle READ 0x012 -> read_data=16'hBEEF with read_valid=1 exactly one cycle later.
REQ-025 The bench SHALL cover: READ 0x001, 0x002, 0x003 on consecutive cycles after preloading 16'h1111, 16'h2222, 16'h3333 -> read_valid high for 3 consecutive cycles with data in order.
REQ-026 The bench SHALL cover: mem_cmd=11 at any address -> cmd_err=1 and staying 1 through later legal commands; pulse reset_n low -> cmd_err=0.
REQ-027 The bench SHALL cover, with MEM_MMIO_EN: WRITE 0x100 <- 16'h00A5 -> led=8'hA5 the next cycle, READ 0x100 -> 16'h00A5; sw=8'h3C held for 2 cycles, READ 0x140 -> 16'h003C.
REQ-028 The bench SHALL cover, without MEM_MMIO_EN: WRITE 0x105 <- 16'h7777, READ 0x005 -> 16'h7777, and led stays 8'h00.
REQ-029 The bench SHALL cover: a READ issued, then reset_n dropped before the next edge -> read_valid stays 0, and all outputs reach their reset values without waiting for a clock edge.
